// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Owner indices double as requester port numbers (0 = CPU MMIO, 1 = debug streamer).
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    function automatic logic [1:0] state_grant(input arb_state_e s);
        case (s)
            ST_OWN0: return 2'b01;
            ST_OWN1: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the two requesters, the arbiter and the UART transmitter.
// The master modport is the surrounding system; the slave modport is the arbiter.
interface uart_tx_arbiter_if;

    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_last;
    logic       req0_ready;

    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_last;
    logic       req1_ready;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    logic [1:0] grant;
    logic       busy;

    modport master (
        output req0_data, req0_valid, req0_last,
        input  req0_ready,
        output req1_data, req1_valid, req1_last,
        input  req1_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        input  grant, busy
    );

    modport slave (
        input  req0_data, req0_valid, req0_last,
        output req0_ready,
        input  req1_data, req1_valid, req1_last,
        output req1_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        output grant, busy
    );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter in front of the UART transmitter, with packet,
// burst-length and stall-timeout release. Data path is combinational from the owner.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BW-1:0] BEAT_MAX  = BW'(MAX_BURST);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
    localparam logic [SW-1:0] STALL_MAX = SW'(IDLE_TIMEOUT);
    localparam logic [SW-1:0] STALL_ONE = SW'(1);

    arb_state_e    state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] beat_q, beat_d, beat_inc;
    logic [SW-1:0] stall_q, stall_d, stall_inc;

    logic [7:0] req_data [2];
    logic [1:0] req_valid;
    logic [1:0] req_last;
    logic [1:0] req_ready;

    logic owned;
    logic owner;
    logic own_valid;
    logic own_last;
    logic xfer;

    assign req_data[0] = bus.req0_data;
    assign req_data[1] = bus.req1_data;
    assign req_valid   = {bus.req1_valid, bus.req0_valid};
    assign req_last    = {bus.req1_last,  bus.req0_last};

    // Outputs are forced quiet while rst is high so an aborted packet moves no byte.
    assign owned     = !rst && ((state_q == ST_OWN0) || (state_q == ST_OWN1));
    assign owner     = (state_q == ST_OWN1) ? OWNER_DBG : OWNER_CPU;
    assign own_valid = owned && req_valid[owner];
    assign own_last  = req_last[owner];
    assign xfer      = own_valid && bus.tx_ready;

    assign beat_inc  = beat_q + BEAT_ONE;
    assign stall_inc = stall_q + STALL_ONE;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = owned && (owner == 1'(gi)) && bus.tx_ready;
        end
    endgenerate

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.tx_data    = owned ? req_data[owner] : 8'h00;
    assign bus.tx_valid   = own_valid;
    assign bus.grant      = owned ? state_grant(state_q) : 2'b00;
    assign bus.busy       = owned;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        stall_d  = stall_q;
        case (state_q)
            ST_IDLE: begin
                beat_d  = '0;
                stall_d = '0;
                if (req_valid[0] && req_valid[1]) begin
                    state_d = rr_ptr_q ? ST_OWN1 : ST_OWN0;
                end else if (req_valid[0]) begin
                    state_d = ST_OWN0;
                end else if (req_valid[1]) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (xfer && (beat_q != BEAT_MAX)) begin
                    beat_d = beat_inc;
                end
                if (own_valid) begin
                    stall_d = '0;
                end else if (stall_q != STALL_MAX) begin
                    stall_d = stall_inc;
                end
                // Any release hands priority to the other requester and always passes through IDLE.
                if ((xfer && (own_last || (beat_inc == BEAT_MAX))) ||
                    (!own_valid && (stall_inc == STALL_MAX))) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = ~owner;
                    beat_d   = '0;
                    stall_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
                stall_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= OWNER_CPU;
            beat_q   <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            stall_q  <= stall_d;
        end
    end

endmodule
